commit_trace_fifo: RTL and testbench

COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

---
 rtl/commit_trace_pkg.sv | 19 +
 rtl/sync_fifo_fwft.sv | 62 ++++++
 rtl/commit_trace_fifo.sv | 92 +++++++++
 tb/tb_commit_trace_fifo.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace buffer: one retired register write plus
// the sequence number it was given when it was seen.
package commit_trace_pkg;

   localparam int SEQ_W  = 16;
   localparam int PC_W   = 32;
   localparam int RD_W   = 5;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] data;
      logic [SEQ_W-1:0]  seq;
   } commit_rec_t;

   localparam int REC_W = PC_W + RD_W + DATA_W + SEQ_W;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through storage FIFO; the head entry is visible on rd_data
// as soon as valid is high.
module sync_fifo_fwft #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             empty;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      level    = wr_ptr_q - rd_ptr_q;
      valid    = !empty;
      do_pop   = pop && !empty && !flush;
      do_push  = push && !flush && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
      rd_data = valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/commit_trace_fifo.sv
// Commit trace buffer: filters x0 writes, numbers eligible commits, buffers
// them for a consumer and counts the ones that had to be dropped.
module commit_trace_fifo
   import commit_trace_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int FILTER_X0 = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   commit_valid,
   input  logic [PC_W-1:0]        commit_pc,
   input  logic [RD_W-1:0]        commit_rd,
   input  logic [DATA_W-1:0]      commit_data,
   input  logic                   flush,
   output logic                   trace_valid,
   input  logic                   trace_ready,
   output logic [PC_W-1:0]        trace_pc,
   output logic [RD_W-1:0]        trace_rd,
   output logic [DATA_W-1:0]      trace_data,
   output logic [SEQ_W-1:0]       trace_seq,
   output logic                   overflow,
   output logic [15:0]            drop_count,
   output logic [$clog2(DEPTH):0] level
);

   localparam logic [15:0] DROP_MAX = 16'hFFFF;

   commit_rec_t      wr_rec;
   commit_rec_t      rd_rec;
   logic             full;
   logic             eligible;
   logic             pop;
   logic             accept;
   logic             drop;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [15:0]      drop_count_q, drop_count_d;
   logic             overflow_q, overflow_d;

   // A flush-cycle commit still burns a sequence number but is not a drop.
   always_comb begin
      eligible     = commit_valid && !((FILTER_X0 != 0) && (commit_rd == '0));
      pop          = trace_valid && trace_ready;
      accept       = eligible && !flush && (!full || pop);
      drop         = eligible && !flush && !accept;
      wr_rec       = '{pc: commit_pc, rd: commit_rd, data: commit_data, seq: seq_q};
      seq_d        = seq_q;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      if (eligible) seq_d = seq_q + 1'b1;
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_count_q != DROP_MAX) drop_count_d = drop_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seq_q        <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         seq_q        <= seq_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   sync_fifo_fwft #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_store (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .push    (accept),
      .pop     (pop),
      .wr_data (wr_rec),
      .rd_data (rd_rec),
      .valid   (trace_valid),
      .full    (full),
      .level   (level)
   );

   assign trace_pc   = rd_rec.pc;
   assign trace_rd   = rd_rec.rd;
   assign trace_data = rd_rec.data;
   assign trace_seq  = rd_rec.seq;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Self-checking bench for commit_trace_fifo: directed vector table, corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_commit_trace_fifo;

   localparam int DEPTH = 16;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [15:0] seq;
   } rec_t;

   typedef struct {
      bit          do_reset;
      bit          cv;
      logic [31:0] pc;
      logic [4:0]  rd;
      bit          ready;
      bit          fl;
      bit          exp_valid;
      int          exp_level;
      logic [31:0] exp_pc;
      int          exp_seq;
      bit          exp_ovf;
      int          exp_dc;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic [4:0]  commit_rd;
   logic [31:0] commit_data;
   logic        flush;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_pc;
   logic [4:0]  trace_rd;
   logic [31:0] trace_data;
   logic [15:0] trace_seq;
   logic        overflow;
   logic [15:0] drop_count;
   logic [4:0]  level;

   int total = 0;
   int bad   = 0;

   rec_t        mq[$];
   logic [15:0] m_seq;
   bit          m_ovf;
   logic [15:0] m_dc;

   always #5 clk = ~clk;

   commit_trace_fifo #(.DEPTH(DEPTH), .FILTER_X0(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .commit_rd    (commit_rd),
      .commit_data  (commit_data),
      .flush        (flush),
      .trace_valid  (trace_valid),
      .trace_ready  (trace_ready),
      .trace_pc     (trace_pc),
      .trace_rd     (trace_rd),
      .trace_data   (trace_data),
      .trace_seq    (trace_seq),
      .overflow     (overflow),
      .drop_count   (drop_count),
      .level        (level)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(bit rst, bit cv, logic [31:0] pc, logic [4:0] rd, bit ready,
                                bit fl, bit ev, int el, logic [31:0] epc, int es, bit eo, int ed);
      vec_t v;
      v.do_reset = rst; v.cv = cv; v.pc = pc; v.rd = rd; v.ready = ready; v.fl = fl;
      v.exp_valid = ev; v.exp_level = el; v.exp_pc = epc; v.exp_seq = es;
      v.exp_ovf = eo; v.exp_dc = ed;
      return v;
   endfunction

   // Reference model: the buffer is just a queue of records; rules taken
   // straight from the behavioural description of accept/drop/flush.
   task automatic modelStep();
      bit   elig;
      bit   pop;
      bit   acc;
      rec_t r;
      pop  = (mq.size() != 0) && trace_ready;
      elig = commit_valid && (commit_rd != 5'd0);
      acc  = elig && !flush && ((mq.size() < DEPTH) || pop);
      if (flush) begin
         mq.delete();
      end else begin
         if (pop) mq.delete(0);
         if (acc) begin
            r.pc = commit_pc; r.rd = commit_rd; r.data = commit_data; r.seq = m_seq;
            mq.push_back(r);
         end
         if (elig && !acc) begin
            m_ovf = 1'b1;
            if (m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
         end
      end
      if (elig) m_seq = m_seq + 16'd1;
   endtask

   task automatic checkOutput();
      check("valid", 32'(trace_valid), 32'(mq.size() != 0));
      check("level", 32'(level), 32'(mq.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("drop_count", 32'(drop_count), 32'(m_dc));
      if (mq.size() != 0) begin
         check("head_pc", trace_pc, mq[0].pc);
         check("head_rd", 32'(trace_rd), 32'(mq[0].rd));
         check("head_data", trace_data, mq[0].data);
         check("head_seq", 32'(trace_seq), 32'(mq[0].seq));
      end
   endtask

   // Drives one cycle of inputs (called at posedge+1), checks outputs against
   // the model mid-cycle, advances the model, and returns at posedge+1.
   task automatic applyStimulus(input bit cv, input logic [31:0] pc, input logic [4:0] rd,
                                input logic [31:0] data, input bit rdy, input bit fl);
      commit_valid = cv;
      commit_pc    = pc;
      commit_rd    = rd;
      commit_data  = data;
      trace_ready  = rdy;
      flush        = fl;
      @(negedge clk);
      checkOutput();
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      commit_valid = 1'b0;
      trace_ready  = 1'b0;
      flush        = 1'b0;
      commit_pc    = '0;
      commit_rd    = '0;
      commit_data  = '0;
      reset        = 1'b1;
      #2;
      check("rst_valid", 32'(trace_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_pc", trace_pc, 32'd0);
      check("rst_rd", 32'(trace_rd), 32'd0);
      check("rst_data", trace_data, 32'd0);
      check("rst_seq", 32'(trace_seq), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_dc", 32'(drop_count), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mq.delete();
      m_seq = '0;
      m_ovf = 1'b0;
      m_dc  = '0;
   endtask

   initial begin
      vec_t        vt[$];
      logic [15:0] old_seq;
      bit          rdy;

      reset = 1'b1;
      @(posedge clk);
      #1;
      resetDut();

      // Back-to-back commits with ready high, then x0 filtering from reset.
      vt.push_back(mkv(1, 1, 32'h0,  5'd1, 1, 0, 1, 1, 32'h0,  0, 0, 0));
      vt.push_back(mkv(0, 1, 32'h4,  5'd2, 1, 0, 1, 1, 32'h4,  1, 0, 0));
      vt.push_back(mkv(0, 1, 32'h8,  5'd3, 1, 0, 1, 1, 32'h8,  2, 0, 0));
      vt.push_back(mkv(0, 0, 32'h0,  5'd0, 1, 0, 0, 0, 32'h0,  0, 0, 0));
      vt.push_back(mkv(1, 1, 32'h10, 5'd0, 0, 0, 0, 0, 32'h0,  0, 0, 0));
      vt.push_back(mkv(0, 1, 32'h14, 5'd5, 0, 0, 1, 1, 32'h14, 0, 0, 0));
      vt.push_back(mkv(0, 0, 32'h0,  5'd0, 1, 0, 0, 0, 32'h0,  0, 0, 0));
      for (int i = 0; i < vt.size(); i++) begin
         if (vt[i].do_reset) resetDut();
         applyStimulus(vt[i].cv, vt[i].pc, vt[i].rd, vt[i].pc + 32'h100, vt[i].ready, vt[i].fl);
         check("vec_valid", 32'(trace_valid), 32'(vt[i].exp_valid));
         check("vec_level", 32'(level), 32'(vt[i].exp_level));
         check("vec_ovf", 32'(overflow), 32'(vt[i].exp_ovf));
         check("vec_dc", 32'(drop_count), 32'(vt[i].exp_dc));
         if (vt[i].exp_valid) begin
            check("vec_pc", trace_pc, vt[i].exp_pc);
            check("vec_seq", 32'(trace_seq), 32'(vt[i].exp_seq));
         end
      end

      // Overfill with the consumer stalled: 16 kept, 2 dropped.
      resetDut();
      for (int i = 0; i < 18; i++)
         applyStimulus(1, 32'h1000 + 32'(i * 4), 5'(i % 31 + 1), $urandom, 0, 0);
      check("fill_level", 32'(level), 32'd16);
      check("fill_dc", 32'(drop_count), 32'd2);
      check("fill_ovf", 32'(overflow), 32'd1);
      check("fill_head_seq", 32'(trace_seq), 32'd0);

      // Full buffer with simultaneous commit and pop: accepted, no new drop.
      applyStimulus(1, 32'h2000, 5'd7, 32'hCAFE, 1, 0);
      check("fullpp_level", 32'(level), 32'd16);
      check("fullpp_dc", 32'(drop_count), 32'd2);

      for (int k = 0; k < 16; k++) begin
         check("drain_seq", 32'(trace_seq), (k < 15) ? 32'(k + 1) : 32'd18);
         applyStimulus(0, 32'h0, 5'd0, 32'h0, 1, 0);
      end
      check("drain_level", 32'(level), 32'd0);

      // Flush at level 5 with a colliding commit.
      for (int i = 0; i < 5; i++)
         applyStimulus(1, 32'h3000 + 32'(i * 4), 5'd9, $urandom, 0, 0);
      check("preflush_level", 32'(level), 32'd5);
      old_seq = m_seq;
      applyStimulus(1, 32'h3100, 5'd9, 32'h0, 1, 1);
      check("flush_level", 32'(level), 32'd0);
      check("flush_valid", 32'(trace_valid), 32'd0);
      check("flush_keep_dc", 32'(drop_count), 32'd2);
      check("flush_keep_ovf", 32'(overflow), 32'd1);
      applyStimulus(1, 32'h3200, 5'd9, 32'h0, 0, 0);
      check("postflush_seq", 32'(trace_seq), 32'(old_seq) + 32'd1);
      check("postflush_seq_abs", 32'(trace_seq), 32'd25);

      // Asynchronous reset mid-stream at level 7.
      for (int i = 0; i < 6; i++)
         applyStimulus(1, 32'h4000 + 32'(i * 4), 5'd3, $urandom, 0, 0);
      check("prerst_level", 32'(level), 32'd7);
      commit_valid = 1'b1;
      trace_ready  = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      check("async_level", 32'(level), 32'd0);
      check("async_valid", 32'(trace_valid), 32'd0);
      check("async_ovf", 32'(overflow), 32'd0);
      check("async_dc", 32'(drop_count), 32'd0);
      @(posedge clk);
      #1;
      resetDut();

      // Randomized traffic: alternate consumer-fast and consumer-slow phases.
      for (int i = 0; i < 3000; i++) begin
         if ((i % 200) < 100) rdy = ($urandom_range(0, 3) != 0);
         else                 rdy = ($urandom_range(0, 3) == 0);
         applyStimulus($urandom_range(0, 9) < 7, $urandom,
                       ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                       $urandom, rdy, $urandom_range(0, 49) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
